// File: rtl/restador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : restador_pkg
// Brief    : Shared types and constants for the sequential add/subtract unit.
//            Holds the FSM state encoding, the op encoding and the bit
//            positions of the packed flag vector.
// Revision : 1.0 - initial release
// ============================================================================
package restador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Bit positions inside the packed flag register
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

endpackage
`default_nettype wire

// File: rtl/restador_secuencial_sumador_digito.sv
`default_nettype none
// ============================================================================
// Module   : sumador_digito
// Brief    : Combinational DIGIT-bit ripple-carry adder. Besides the carry
//            out it exposes the carry into its top bit, which the parent
//            needs for signed-overflow detection on the last digit.
// Revision : 1.0 - initial release
// ============================================================================
module sumador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  logic [DIGIT:0] w_c;

  // Ripple the carry bit by bit through the digit
  always_comb begin
    w_c    = '0;
    s_o    = '0;
    w_c[0] = cin_i;
    for (int i = 0; i < DIGIT; i++) begin
      s_o[i]   = x_i[i] ^ y_i[i] ^ w_c[i];
      w_c[i+1] = (x_i[i] & y_i[i]) | (w_c[i] & (x_i[i] ^ y_i[i]));
    end
  end

  assign cout_o = w_c[DIGIT];
  assign cmsb_o = w_c[DIGIT-1];

endmodule
`default_nettype wire

// File: rtl/restador_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : restador_secuencial
// Brief    : Digit-serial add/subtract unit with valid/ready handshakes.
//            Processes DIGIT bits per cycle LSB-first and reports Z/N/C/V.
//            Optional macro RESTADOR_SAT_EN: clamp the result to the signed
//            range limit on overflow instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module restador_secuencial
  import restador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             z_o,
  output logic             n_o,
  output logic             c_o,
  output logic             v_o
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_chk
      $error("restador_secuencial: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   a_q;        // minuend shifts out, result shifts in
  logic [WIDTH-1:0]   b_q;        // already inverted for subtraction
  logic               carry_q;
  logic [WIDTH-1:0]   y_q;
  logic [FLAG_W-1:0]  flags_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [DIGIT-1:0]   w_s;
  logic               w_cout;
  logic               w_cmsb;
  logic [WIDTH-1:0]   a_d;
  logic [WIDTH-1:0]   y_d;
  logic [FLAG_W-1:0]  flags_d;
  logic               w_v;

  sumador_digito #(
    .DIGIT (DIGIT)
  ) u_sumador (
    .x_i    (a_q[DIGIT-1:0]),
    .y_i    (b_q[DIGIT-1:0]),
    .cin_i  (carry_q),
    .s_o    (w_s),
    .cout_o (w_cout),
    .cmsb_o (w_cmsb)
  );

  // Next value of the shared operand/result shift register
  generate
    if (NDIG == 1) begin : g_single_digit
      assign a_d = w_s;
    end else begin : g_multi_digit
      assign a_d = {w_s, a_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  // On the last digit a_d holds the full wrapped sum; derive result and flags
  always_comb begin
    w_v = w_cmsb ^ w_cout;
`ifdef RESTADOR_SAT_EN
    // A wrapped negative-looking result means the true result was positive
    if (w_v) begin
      y_d = a_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      y_d = a_d;
    end
`else
    y_d = a_d;
`endif
    flags_d         = '0;
    flags_d[FLAG_Z] = (y_d == '0);
    flags_d[FLAG_N] = y_d[WIDTH-1];
    flags_d[FLAG_C] = w_cout;
    flags_d[FLAG_V] = w_v;
  end

  // Control FSM with datapath registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      y_q         <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q        <= a_i;
            b_q        <= (op_i == OP_SUB) ? ~b_i : b_i;
            carry_q    <= (op_i == OP_SUB);
            cnt_q      <= '0;
            state_q    <= CALC;
            in_ready_q <= 1'b0;
          end
        end
        CALC: begin
          a_q     <= a_d;
          b_q     <= b_q >> DIGIT;
          carry_q <= w_cout;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == CW'(NDIG - 1)) begin
            y_q         <= y_d;
            flags_q     <= flags_d;
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign y_o         = y_q;
  assign z_o         = flags_q[FLAG_Z];
  assign n_o         = flags_q[FLAG_N];
  assign c_o         = flags_q[FLAG_C];
  assign v_o         = flags_q[FLAG_V];

endmodule
`default_nettype wire

// File: tb/tb_restador_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_restador_secuencial
// Brief    : Self-checking bench: a 4-bit serial instance checked every cycle
//            against an arithmetic model, plus an 8-bit/4-bit-digit instance
//            with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_restador_secuencial;

`ifdef RESTADOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  // 4-bit, 1 bit per cycle
  logic       in_valid, in_ready, op, out_valid, out_ready, z, n, c, v;
  logic [3:0] a, b, y;
  // 8-bit, 4 bits per cycle
  logic       in_valid8, in_ready8, op8, out_valid8, out_ready8, z8, n8, c8, v8;
  logic [7:0] a8, b8, y8;

  int tests = 0;
  int fails = 0;

  restador_secuencial #(.WIDTH(4), .DIGIT(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .op_i(op), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .y_o(y), .z_o(z), .n_o(n), .c_o(c), .v_o(v)
  );

  restador_secuencial #(.WIDTH(8), .DIGIT(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid8), .in_ready_o(in_ready8),
    .a_i(a8), .b_i(b8), .op_i(op8), .out_valid_o(out_valid8), .out_ready_i(out_ready8),
    .y_o(y8), .z_o(z8), .n_o(n8), .c_o(c8), .v_o(v8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected {v,c,n,z, y[3:0]} from plain integer arithmetic
  function automatic logic [7:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mop);
    int ua, ub, sa, sb, t, u, yy;
    bit cc, vv;
    ua = int'(ma);
    ub = int'(mb);
    sa = (ua > 7) ? ua - 16 : ua;
    sb = (ub > 7) ? ub - 16 : ub;
    t  = mop ? sa + sb : sa - sb;
    u  = mop ? ua + ub : ua - ub;
    yy = (u + 32) % 16;
    cc = mop ? (u > 15) : (ua >= ub);
    vv = (t > 7) || (t < -8);
    if (SAT && vv) yy = (t > 0) ? 7 : 8;
    model = {vv, cc, yy[3], (yy == 0), 4'(yy)};
  endfunction

  // Transaction-level model of the 4-bit instance
  int         m_busy = 0;
  bit         m_done = 1'b0;
  logic [7:0] m_pend = '0;
  logic [7:0] m_exp  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_done = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_done = 1'b1;
        m_exp  = m_pend;
      end
    end else if (in_valid) begin
      m_pend = model(a, b, op);
      m_busy = 4;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_in_ready", in_ready, (m_busy == 0) && !m_done);
      check("cmp_out_valid", out_valid, m_done);
      if (m_done) begin
        check("cmp_y", y, m_exp[3:0]);
        check("cmp_flags", {v, c, n, z}, m_exp[7:4]);
      end
    end
  end

  task automatic run_op(input string nm, input logic [3:0] ta, input logic [3:0] tb,
                        input logic top, input logic [3:0] ey, input logic [3:0] ef,
                        input int hold);
    int lat;
    bit seen;
    @(posedge clk); #1;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    @(posedge clk); #1;
    // accepted at that edge; disturb inputs to show they are ignored
    in_valid = 1'b0; a = ~ta; b = ta ^ tb; op = ~top;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = (lat == 1);
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    check({nm, "_latency"}, lat, 4);
    check({nm, "_y"}, y, ey);
    check({nm, "_flags"}, {v, c, n, z}, ef);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({nm, "_hold_y"}, y, ey);
      check({nm, "_hold_flags"}, {v, c, n, z}, ef);
      check({nm, "_hold_in_ready"}, in_ready, 1'b0);
    end
    // in_valid high on the handshake edge must not start a new operation
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check({nm, "_post_in_ready"}, in_ready, 1'b1);
    check({nm, "_post_out_valid"}, out_valid, 1'b0);
    @(posedge clk); #1;
    check({nm, "_still_idle"}, in_ready, 1'b1);
  endtask

  task automatic run8(input string nm, input logic [7:0] ta, input logic [7:0] tb,
                      input logic top, input logic [7:0] ey, input logic [3:0] ef);
    int lat;
    bit seen;
    @(posedge clk); #1;
    a8 = ta; b8 = tb; op8 = top; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid8) seen = 1'b1;
    end
    check({nm, "_latency"}, lat, 2);
    check({nm, "_y"}, y8, ey);
    check({nm, "_flags"}, {v8, c8, n8, z8}, ef);
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    check({nm, "_post_in_ready"}, in_ready8, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; op8 = 1'b0; out_ready8 = 1'b0;
    #12;
    check("rst_y", y, 4'h0);
    check("rst_flags", {v, c, n, z}, 4'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    // release alone must not start anything
    repeat (3) @(posedge clk);
    #1;
    check("rel_in_ready", in_ready, 1'b1);
    check("rel_out_valid", out_valid, 1'b0);

    run_op("sub_5_3",  4'd5, 4'd3,  1'b0, 4'b0010, 4'b0100, 0);
    run_op("sub_3_5",  4'd3, 4'd5,  1'b0, 4'b1110, 4'b0010, 1);
    run_op("sub_7_7",  4'd7, 4'd7,  1'b0, 4'b0000, 4'b0101, 0);
    run_op("sub_7_15", 4'd7, 4'd15, 1'b0, SAT ? 4'b0111 : 4'b1000,
           SAT ? 4'b1000 : 4'b1010, 0);
    run_op("sub_8_1",  4'd8, 4'd1,  1'b0, SAT ? 4'b1000 : 4'b0111,
           SAT ? 4'b1110 : 4'b1100, 5);
    run_op("add_7_1",  4'd7, 4'd1,  1'b1, SAT ? 4'b0111 : 4'b1000,
           SAT ? 4'b1000 : 4'b1010, 0);
    run_op("add_15_1", 4'd15, 4'd1, 1'b1, 4'b0000, 4'b0101, 0);
    run_op("add_2_3",  4'd2, 4'd3,  1'b1, 4'b0101, 4'b0000, 0);

    // reset in the middle of a calculation
    @(posedge clk); #1;
    a = 4'd5; b = 4'd3; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_y", y, 4'h0);
    check("midrst_flags", {v, c, n, z}, 4'h0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_rel_in_ready", in_ready, 1'b1);
    run_op("sub_0_1", 4'd0, 4'd1, 1'b0, 4'b1111, 4'b0010, 0);

    // 8-bit, two digits of four bits
    check("w8_rst_y", y8, 8'h00);
    run8("w8_sub_80_01", 8'h80, 8'h01, 1'b0, SAT ? 8'h80 : 8'h7F,
         SAT ? 4'b1110 : 4'b1100);
    run8("w8_add_7f_01", 8'h7F, 8'h01, 1'b1, SAT ? 8'h7F : 8'h80,
         SAT ? 4'b1000 : 4'b1010);
    run8("w8_add_12_34", 8'h12, 8'h34, 1'b1, 8'h46, 4'b0000);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
